hit_judge_multi: RTL and testbench
==================================

Name: hit_judge_multi

Overview:
- Parametrised successor of the two-button judge.
- Judges N independent lanes against the per-lane note-present flags and the shared timing offset from shift.
- Edge-detects presses, grades each hit, and queues graded hits so that one result per cycle reaches score.v.
- Tracks current combo and maximum combo for display.

Parameters:
- LANES, 2, number of button/note lanes (1..8).
- OFFSET_W, 3, width of the offset input.
- EARLY_OFF, 1, offset graded EARLY.
- PERFECT_LO, 2, lowest offset graded PERFECT.
- PERFECT_HI, 4, highest offset graded PERFECT.
- LATE_OFF, 5, offset graded LATE.
- COMBO_W, 8, width of combo counters.
- GHOST_BREAK, 1, when 1 a press with no note resets the combo.
- DEBOUNCE_CYC, 4, stable cycles required before an edge is accepted (DEBOUNCE_EN only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- button  in  LANES  raw button levels, one bit per lane.
- note  in  LANES  note present in the hit zone, per lane.
- offset  in  OFFSET_W  current note offset from shift.
- delete_note  out  LANES  one-cycle pulse per lane: consume that lane's note.
- score_valid  out  1  one-cycle strobe; score and score_lane are valid.
- score  out  2  grade: 11 PERFECT, 10 LATE, 01 EARLY, 00 MISS.
- score_lane  out  $clog2(LANES) or 1  lane that produced score.
- combo  out  COMBO_W  current consecutive non-MISS hit count.
- max_combo  out  COMBO_W  highest combo since reset.

Behaviour:
- Reset (async, rst=1): btn_q, pending, grade registers, delete_note, score_valid, score, score_lane, combo and max_combo all go to 0. Presses in flight are dropped.
- Edge detect: btn_q <= button each clock. press[i] = button[i] & ~btn_q[i]. A held button produces exactly one press.
- Judging at edge k when press[i]=1 and note[i]=1:
  - delete_note[i]=1 for the cycle after edge k.
  - grade[i] from offset: PERFECT_LO..PERFECT_HI gives 11; LATE_OFF gives 10; EARLY_OFF gives 01; any other offset gives 00.
  - pending[i] is set.
- Ghost press (press[i]=1, note[i]=0):
  - No delete, no pending.
  - If GHOST_BREAK=1, combo <= 0 at edge k.
- Output arbiter, each edge:
  - If any pending bit was set before this edge, select the lowest-index pending lane j.
  - Drive score_valid=1, score=grade[j], score_lane=j; clear pending[j].
  - Otherwise score_valid=0. score and score_lane hold their last values.
- Latency: press sampled at edge k gives delete_note after k and score_valid after k+1, when no other lane has priority.
- Simultaneous presses on m lanes: m delete pulses in the same cycle; results issued on consecutive cycles, ascending lane order.
- Re-press on a lane whose pending bit is still set and not issued this edge: the new grade overwrites the old one; only one result is emitted.
- Re-press on a lane being issued this same edge: the old grade is issued, and the new grade is captured and pending stays set.
- Combo update, on issued results only:
  - Non-MISS: combo increments, saturating at all-ones.
  - MISS: combo <= 0.
  - If GHOST_BREAK=1 and a ghost press occurs at the same edge as a non-MISS issue, the clear wins.
- max_combo <= max(max_combo, next combo) every edge.
- Pure synchronous logic apart from the reset. No combinational path from inputs to outputs.

Optional Feature:
- Macro HIT_JUDGE_DEBOUNCE_EN.
- Defined: each lane has a counter of $clog2(DEBOUNCE_CYC+1) bits. The internal debounced level changes only after the raw button differs from it for DEBOUNCE_CYC consecutive cycles. Edge detect uses the debounced level, which adds DEBOUNCE_CYC cycles of press latency. Glitches shorter than DEBOUNCE_CYC produce no press.
- Undefined: no counters; raw button feeds edge detect directly.

Test Plan:
- Lane 0 press, note[0]=1, offset=3 -> delete_note=01 for 1 cycle; next cycle score_valid=1, score=11, score_lane=0, combo=1.
- Lanes 0 and 1 press same edge, offsets 1 and 1, notes set -> delete_note=11 once; score 01 lane 0, then 01 lane 1 on the next cycle; combo=2.
- Button held high for 10 cycles with note=1 -> exactly one delete pulse and one score_valid.
- Press with offset=6, note=1 -> delete pulse, score=00, combo reset to 0; max_combo keeps its prior value.
- Ghost press, note=0, GHOST_BREAK=1, combo=5 -> no delete, no score_valid, combo=0.
- rst asserted mid-cycle while pending=11 -> all outputs 0 immediately; no score_valid after release. With HIT_JUDGE_DEBOUNCE_EN: a 2-cycle glitch produces no press; a 6-cycle press produces a score DEBOUNCE_CYC cycles later than without the macro.

Source files
------------

// File: rtl/hit_judge_multi_if.sv
// hit_judge_multi_if: lane inputs and graded-result outputs of the multi-lane hit judge
interface hit_judge_multi_if #(
  parameter int LANES    = 2,
  parameter int OFFSET_W = 3,
  parameter int COMBO_W  = 8,
  parameter int LW       = (LANES > 1) ? $clog2(LANES) : 1
);
  logic [LANES-1:0]    button;
  logic [LANES-1:0]    note;
  logic [OFFSET_W-1:0] offset;
  logic [LANES-1:0]    delete_note;
  logic                score_valid;
  logic [1:0]          score;
  logic [LW-1:0]       score_lane;
  logic [COMBO_W-1:0]  combo;
  logic [COMBO_W-1:0]  max_combo;
  modport master (output button, note, offset,
                  input  delete_note, score_valid, score, score_lane, combo, max_combo);
  modport slave  (input  button, note, offset,
                  output delete_note, score_valid, score, score_lane, combo, max_combo);
endinterface

// File: rtl/hit_judge_multi.sv
// hit_judge_multi: N-lane press judge with grading, lowest-lane result arbiter and combo tracking.
// Optional HIT_JUDGE_DEBOUNCE_EN adds a per-lane debounce filter ahead of edge detection.
module hit_judge_multi #(
  parameter int LANES        = 2,
  parameter int OFFSET_W     = 3,
  parameter int EARLY_OFF    = 1,
  parameter int PERFECT_LO   = 2,
  parameter int PERFECT_HI   = 4,
  parameter int LATE_OFF     = 5,
  parameter int COMBO_W      = 8,
  parameter int GHOST_BREAK  = 1,
  parameter int DEBOUNCE_CYC = 4
) (
  input logic clk,
  input logic rst,
  hit_judge_multi_if.slave bus
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  logic [LANES-1:0] lvl, btn_q, press, hit, ghost, pending, issue;
  logic [1:0] grade [LANES];
  logic [1:0] new_grade;
  logic [LW-1:0] sel;
  logic [COMBO_W-1:0] combo_nx;
  int off;
`ifdef HIT_JUDGE_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic [CW-1:0] cnt [LANES];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl <= '0;
      for (int i = 0; i < LANES; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.button[i] == lvl[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYC - 1)) begin
          cnt[i] <= '0;
          lvl[i] <= ~lvl[i];
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
`else
  assign lvl = bus.button;
`endif
  assign press = lvl & ~btn_q;
  assign hit   = press & bus.note;
  assign ghost = press & ~bus.note;
  // isolate lowest set pending bit
  assign issue = pending & (~pending + 1'b1);
  always_comb begin
    off = int'(bus.offset);
    new_grade = (off >= PERFECT_LO && off <= PERFECT_HI) ? 2'b11 :
                (off == LATE_OFF)  ? 2'b10 :
                (off == EARLY_OFF) ? 2'b01 : 2'b00;
    sel = '0;
    for (int i = LANES - 1; i >= 0; i--) if (pending[i]) sel = LW'(i);
    combo_nx = bus.combo;
    if (|pending) combo_nx = (grade[sel] == 2'b00) ? '0 : (&bus.combo) ? bus.combo : bus.combo + 1'b1;
    if (GHOST_BREAK != 0 && |ghost) combo_nx = '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q           <= '0;
      pending         <= '0;
      bus.delete_note <= '0;
      bus.score_valid <= 1'b0;
      bus.score       <= '0;
      bus.score_lane  <= '0;
      bus.combo       <= '0;
      bus.max_combo   <= '0;
      for (int i = 0; i < LANES; i++) grade[i] <= '0;
    end else begin
      btn_q           <= lvl;
      pending         <= (pending & ~issue) | hit;
      bus.delete_note <= hit;
      bus.score_valid <= |pending;
      if (|pending) begin
        bus.score      <= grade[sel];
        bus.score_lane <= sel;
      end
      bus.combo     <= combo_nx;
      bus.max_combo <= (combo_nx > bus.max_combo) ? combo_nx : bus.max_combo;
      for (int i = 0; i < LANES; i++) if (hit[i]) grade[i] <= new_grade;
    end
  end
endmodule

// File: tb/tb_hit_judge_multi.sv
// tb_hit_judge_multi: reference-model scoreboard plus directed literal checks for hit_judge_multi
module tb_hit_judge_multi;
  localparam int L = 2;
  localparam int D = 4;
  localparam int CMAX = 255;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  hit_judge_multi_if #(.LANES(L), .OFFSET_W(3), .COMBO_W(8)) bus ();
  hit_judge_multi #(.LANES(L)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  function automatic int grade_of(input int o);
    if (o >= 2 && o <= 4) return 3;
    if (o == 5) return 2;
    if (o == 1) return 1;
    return 0;
  endfunction

  // reference model: lane state as plain flags and integers
  bit m_prev [L];
  bit m_pend [L];
  int m_grade [L];
  bit m_lvl [L];
  int m_run [L];
  int m_combo, m_max;
  int w_delete, w_valid, w_score, w_lane;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) begin
        m_prev[i] = 0; m_pend[i] = 0; m_grade[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
      end
      m_combo = 0; m_max = 0; w_delete = 0; w_valid = 0; w_score = 0; w_lane = 0;
    end else begin
      int j, nc;
      bit ghost;
      bit level [L];
      for (int i = 0; i < L; i++) begin
`ifdef HIT_JUDGE_DEBOUNCE_EN
        level[i] = m_lvl[i];
        if (bus.button[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin m_lvl[i] = ~m_lvl[i]; m_run[i] = 0; end
        end else m_run[i] = 0;
        level[i] = m_lvl[i];
`else
        level[i] = bus.button[i];
`endif
      end
      j = -1;
      for (int i = 0; i < L; i++) if (m_pend[i] && j < 0) j = i;
      nc = m_combo;
      w_valid = (j >= 0);
      if (j >= 0) begin
        w_score = m_grade[j];
        w_lane = j;
        m_pend[j] = 0;
        nc = (m_grade[j] == 0) ? 0 : (m_combo + 1 > CMAX ? CMAX : m_combo + 1);
      end
      ghost = 0;
      w_delete = 0;
      for (int i = 0; i < L; i++) begin
        if (level[i] && !m_prev[i]) begin
          if (bus.note[i]) begin
            w_delete |= (1 << i);
            m_grade[i] = grade_of(int'(bus.offset));
            m_pend[i] = 1;
          end else ghost = 1;
        end
        m_prev[i] = level[i];
      end
      if (ghost) nc = 0;
      m_combo = nc;
      if (nc > m_max) m_max = nc;
    end
  end

  always @(negedge clk) begin
    chk("delete_note", 32'(bus.delete_note), w_delete);
    chk("score_valid", 32'(bus.score_valid), w_valid);
    chk("score", 32'(bus.score), w_score);
    chk("score_lane", 32'(bus.score_lane), w_lane);
    chk("combo", 32'(bus.combo), m_combo);
    chk("max_combo", 32'(bus.max_combo), m_max);
  end

  task automatic set(input logic [1:0] b, input logic [1:0] n, input logic [2:0] o);
    bus.button = b; bus.note = n; bus.offset = o;
  endtask
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int nd, nv, first;
    set(0, 0, 0);
    tick(); tick();
    rst = 0;
    tick();
    chk("reset_combo", 32'(bus.combo), 0);
    chk("reset_max", 32'(bus.max_combo), 0);
    chk("reset_valid", 32'(bus.score_valid), 0);
`ifndef HIT_JUDGE_DEBOUNCE_EN
    set(2'b01, 2'b01, 3); tick();
    chk("t1_delete", 32'(bus.delete_note), 1);
    chk("t1_novalid", 32'(bus.score_valid), 0);
    set(0, 0, 0); tick();
    chk("t1_valid", 32'(bus.score_valid), 1);
    chk("t1_score", 32'(bus.score), 3);
    chk("t1_lane", 32'(bus.score_lane), 0);
    chk("t1_combo", 32'(bus.combo), 1);
    set(2'b11, 2'b11, 1); tick();
    chk("t2_delete", 32'(bus.delete_note), 3);
    set(0, 0, 0); tick();
    chk("t2_v0", 32'(bus.score_valid), 1);
    chk("t2_s0", 32'(bus.score), 1);
    chk("t2_l0", 32'(bus.score_lane), 0);
    tick();
    chk("t2_v1", 32'(bus.score_valid), 1);
    chk("t2_s1", 32'(bus.score), 1);
    chk("t2_l1", 32'(bus.score_lane), 1);
    chk("t2_combo", 32'(bus.combo), 3);
    tick();
    chk("t2_idle", 32'(bus.score_valid), 0);
    nd = 0; nv = 0;
    set(2'b01, 2'b01, 2);
    for (int i = 0; i < 10; i++) begin
      tick();
      nd += (bus.delete_note != 0);
      nv += bus.score_valid;
    end
    set(0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      nd += (bus.delete_note != 0);
      nv += bus.score_valid;
    end
    chk("t3_deletes", nd, 1);
    chk("t3_valids", nv, 1);
    chk("t3_combo", 32'(bus.combo), 4);
    set(2'b10, 2'b10, 6); tick();
    chk("t4_delete", 32'(bus.delete_note), 2);
    set(0, 0, 0); tick();
    chk("t4_valid", 32'(bus.score_valid), 1);
    chk("t4_score", 32'(bus.score), 0);
    chk("t4_lane", 32'(bus.score_lane), 1);
    chk("t4_combo", 32'(bus.combo), 0);
    chk("t4_max", 32'(bus.max_combo), 4);
    for (int i = 0; i < 5; i++) begin
      set(2'b01, 2'b01, 3); tick();
      set(0, 0, 0); tick();
    end
    chk("t5_combo5", 32'(bus.combo), 5);
    chk("t5_max5", 32'(bus.max_combo), 5);
    set(2'b01, 2'b00, 3); tick();
    chk("t5_ghost_delete", 32'(bus.delete_note), 0);
    chk("t5_ghost_valid", 32'(bus.score_valid), 0);
    chk("t5_ghost_combo", 32'(bus.combo), 0);
    set(0, 0, 0); tick();
    chk("t5_after_valid", 32'(bus.score_valid), 0);
    chk("t5_after_max", 32'(bus.max_combo), 5);
    set(2'b10, 2'b10, 3); tick();
    set(2'b01, 2'b00, 3); tick();
    chk("t5b_valid", 32'(bus.score_valid), 1);
    chk("t5b_clear_wins", 32'(bus.combo), 0);
    set(0, 0, 0); tick();
    set(2'b11, 2'b11, 5); tick();
    set(0, 0, 0); tick();
    chk("t6_first_lane", 32'(bus.score_lane), 0);
    chk("t6_first_score", 32'(bus.score), 2);
    set(2'b10, 2'b10, 1); tick();
    chk("t6_repress_delete", 32'(bus.delete_note), 2);
    chk("t6_old_score", 32'(bus.score), 2);
    chk("t6_old_lane", 32'(bus.score_lane), 1);
    set(0, 0, 0); tick();
    chk("t6_new_valid", 32'(bus.score_valid), 1);
    chk("t6_new_score", 32'(bus.score), 1);
    chk("t6_new_lane", 32'(bus.score_lane), 1);
    tick();
    chk("t6_done", 32'(bus.score_valid), 0);
`else
    nd = 0; nv = 0;
    set(2'b01, 2'b01, 3); tick(); tick();
    set(0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      nd += (bus.delete_note != 0);
      nv += bus.score_valid;
    end
    chk("db_glitch_deletes", nd, 0);
    chk("db_glitch_valids", nv, 0);
    first = 0;
    set(2'b01, 2'b01, 3);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (bus.score_valid && first == 0) first = i;
      if (i == 6) set(0, 0, 0);
    end
    chk("db_latency", first, D + 2);
    chk("db_score", 32'(bus.score), 3);
    chk("db_combo", 32'(bus.combo), 1);
`endif
    set(2'b11, 2'b11, 3);
    for (int i = 0; i < D + 1; i++) tick();
    #2 rst = 1;
    #1;
    chk("rst_delete", 32'(bus.delete_note), 0);
    chk("rst_valid", 32'(bus.score_valid), 0);
    chk("rst_score", 32'(bus.score), 0);
    chk("rst_lane", 32'(bus.score_lane), 0);
    chk("rst_combo", 32'(bus.combo), 0);
    chk("rst_max", 32'(bus.max_combo), 0);
    set(0, 0, 0);
    tick();
    rst = 0;
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      nv += bus.score_valid;
    end
    chk("rst_no_valid", nv, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
